// File: rtl/kalman_ss_filter.sv
// Steady-state Kalman estimator (predict, innovate, correct) sharing one signed MAC.
// Build option KF_SATURATE_EN: clamp each row result to W bits instead of wrapping.

module kalman_ss_filter #(
    parameter int N_STATES = 4,
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int ADDR_W   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_begin,
    input  logic signed [W-1:0]   i_u,
    input  logic signed [W-1:0]   i_y,
    input  logic                  i_clear,
    input  logic                  i_cfg_we,
    input  logic [ADDR_W-1:0]     i_cfg_addr,
    input  logic signed [W-1:0]   i_cfg_data,
    output logic [N_STATES*W-1:0] o_state,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_ovf
);

    localparam int NN  = N_STATES * N_STATES;
    localparam int NC  = NN + 3 * N_STATES;
    localparam int CIW = $clog2(NC);
    localparam int RW  = $clog2(N_STATES);
    localparam int CW  = $clog2(N_STATES + 1);
    localparam int AW  = 2 * W + 3;

    localparam logic [CW-1:0]       COL_N    = CW'(N_STATES);
    localparam logic [CW-1:0]       COL_LAST = CW'(N_STATES - 1);
    localparam logic [RW-1:0]       ROW_LAST = RW'(N_STATES - 1);
    localparam logic [ADDR_W:0]     CFG_LIM  = (ADDR_W + 1)'(NC);
    localparam logic signed [W-1:0] S_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN    = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {ST_IDLE, ST_PRED, ST_INNOV, ST_CORR, ST_DONE} state_t;

    state_t                state, state_nxt;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic signed [W-1:0]   coef [NC];
    logic signed [W-1:0]   x    [N_STATES];
    logic signed [W-1:0]   xp   [N_STATES];
    logic signed [W-1:0]   u_q, y_q, e_q;
    logic signed [AW-1:0]  acc;
    logic                  ovf_q, overrun_q;
    logic [N_STATES*W-1:0] state_q;

    logic signed [W-1:0]   mac_a, mac_b, res_store;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  prod_ext, base, mac_sum, res_shift;
    logic                  first, last, ovf_now;
    int                    ai;

    // Operand selection: A/B rows in PRED, -C.x' on top of y in INNOV, K*e on top of x' in CORR.
    always_comb begin
        ai    = 0;
        mac_b = '0;
        base  = '0;
        first = 1'b0;
        last  = 1'b0;
        case (state)
            ST_PRED: begin
                if (col == COL_N) begin
                    ai    = NN + int'(row);
                    mac_b = u_q;
                end else begin
                    ai    = int'(row) * N_STATES + int'(col);
                    mac_b = x[RW'(col)];
                end
                first = (col == '0);
                last  = (col == COL_N);
            end
            ST_INNOV: begin
                ai    = NN + N_STATES + int'(col);
                mac_b = xp[RW'(col)];
                base  = {{(AW-W-FRAC){y_q[W-1]}}, y_q, {FRAC{1'b0}}};
                first = (col == '0);
                last  = (col == COL_LAST);
            end
            ST_CORR: begin
                ai    = NN + 2 * N_STATES + int'(col);
                mac_b = e_q;
                base  = {{(AW-W-FRAC){xp[RW'(col)][W-1]}}, xp[RW'(col)], {FRAC{1'b0}}};
                first = 1'b1;
                last  = 1'b1;
            end
            default: ;
        endcase
        mac_a    = coef[CIW'(ai)];
        prod     = (2*W)'(mac_a) * (2*W)'(mac_b);
        prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};
        if (state == ST_INNOV)
            prod_ext = -prod_ext;
        mac_sum   = (first ? base : acc) + prod_ext;
        res_shift = mac_sum >>> FRAC;
        ovf_now   = !((&res_shift[AW-1:W-1]) || !(|res_shift[AW-1:W-1]));
`ifdef KF_SATURATE_EN
        res_store = ovf_now ? (res_shift[AW-1] ? S_MIN : S_MAX) : res_shift[W-1:0];
`else
        res_store = res_shift[W-1:0];
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_begin && !i_clear) state_nxt = ST_PRED;
            ST_PRED:  if (i_clear) state_nxt = ST_IDLE;
                      else if (col == COL_N && row == ROW_LAST) state_nxt = ST_INNOV;
            ST_INNOV: if (i_clear) state_nxt = ST_IDLE;
                      else if (col == COL_LAST) state_nxt = ST_CORR;
            ST_CORR:  if (i_clear) state_nxt = ST_IDLE;
                      else if (col == COL_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            u_q       <= '0;
            y_q       <= '0;
            e_q       <= '0;
            acc       <= '0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= '0;
            for (int i = 0; i < NC; i++) coef[i] <= '0;
            for (int i = 0; i < N_STATES; i++) begin
                x[i]  <= '0;
                xp[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            overrun_q <= (state != ST_IDLE) && i_begin && !i_clear;
            if (state == ST_IDLE && i_cfg_we && ({1'b0, i_cfg_addr} < CFG_LIM))
                coef[CIW'(i_cfg_addr)] <= i_cfg_data;
            if (i_clear) begin
                row     <= '0;
                col     <= '0;
                state_q <= '0;
                for (int i = 0; i < N_STATES; i++) begin
                    x[i]  <= '0;
                    xp[i] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: if (i_begin) begin
                        u_q   <= i_u;
                        y_q   <= i_y;
                        ovf_q <= 1'b0;
                        row   <= '0;
                        col   <= '0;
                    end
                    ST_PRED: begin
                        acc <= mac_sum;
                        if (last) begin
                            xp[row] <= res_store;
                            ovf_q   <= ovf_q | ovf_now;
                            col     <= '0;
                            row     <= (row == ROW_LAST) ? '0 : row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    ST_INNOV: begin
                        acc <= mac_sum;
                        if (last) begin
                            e_q   <= res_store;
                            ovf_q <= ovf_q | ovf_now;
                            col   <= '0;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    ST_CORR: begin
                        x[RW'(col)] <= res_store;
                        ovf_q       <= ovf_q | ovf_now;
                        col         <= (col == COL_LAST) ? '0 : col + CW'(1);
                    end
                    ST_DONE: for (int i = 0; i < N_STATES; i++) state_q[i*W +: W] <= x[i];
                    default: ;
                endcase
            end
        end
    end

    // During DONE the freshly corrected x is presented directly so it coincides with o_valid.
    always_comb begin
        o_state = state_q;
        if (state == ST_DONE)
            for (int i = 0; i < N_STATES; i++) o_state[i*W +: W] = x[i];
    end

    assign o_busy    = (state != ST_IDLE);
    assign o_valid   = (state == ST_DONE);
    assign o_ovf     = o_valid & ovf_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_kalman_ss_filter.sv
// Scoreboarded bench for kalman_ss_filter; expected estimates come from a wide-integer model.
// Honours KF_SATURATE_EN the same way as the design.

module tb_kalman_ss_filter;

    localparam logic [31:0]         ONE    = 32'h0001_0000;
    localparam logic signed [127:0] LIM_HI = 128'sh7FFF_FFFF;
    localparam logic signed [127:0] LIM_LO = -128'sh8000_0000;

    logic          i_clk = 1'b0, i_rst_n = 1'b0, i_begin = 1'b0, i_clear = 1'b0, i_cfg_we = 1'b0;
    logic [31:0]   i_u = '0, i_y = '0, i_cfg_data = '0;
    logic [5:0]    i_cfg_addr = '0;
    logic [127:0]  o_state;
    logic          o_valid, o_busy, o_overrun, o_ovf;

    kalman_ss_filter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_begin(i_begin), .i_u(i_u), .i_y(i_y),
        .i_clear(i_clear), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .o_state(o_state), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [127:0] st; logic ovf; int cycle; } exp_t;
    exp_t sbQ[$];

    int nTests = 0, nFailed = 0, cyc = 0, nOverrun = 0;
    logic signed [31:0] mCoef [28];
    logic signed [31:0] mX    [4];

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) if (o_overrun) nOverrun++;

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] fitRow(input logic signed [127:0] v);
        logic signed [127:0] sh;
        sh = v >>> 16;
`ifdef KF_SATURATE_EN
        if (sh > LIM_HI) return {1'b1, 32'h7FFF_FFFF};
        if (sh < LIM_LO) return {1'b1, 32'h8000_0000};
`else
        if (sh > LIM_HI || sh < LIM_LO) return {1'b1, sh[31:0]};
`endif
        return {1'b0, sh[31:0]};
    endfunction

    task automatic modelStep(input logic [31:0] u, input logic [31:0] y,
                             output logic [127:0] st, output logic ovf);
        logic signed [127:0] s, a, b;
        logic signed [31:0]  xp [4];
        logic signed [31:0]  e;
        logic [32:0]         r;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = '0;
            for (int j = 0; j < 4; j++) begin
                a = mCoef[i*4+j]; b = mX[j]; s = s + a * b;
            end
            a = mCoef[16+i]; b = $signed(u); s = s + a * b;
            r = fitRow(s); ovf |= r[32]; xp[i] = r[31:0];
        end
        a = $signed(y); s = a <<< 16;
        for (int j = 0; j < 4; j++) begin
            a = mCoef[20+j]; b = xp[j]; s = s - a * b;
        end
        r = fitRow(s); ovf |= r[32]; e = r[31:0];
        for (int i = 0; i < 4; i++) begin
            a = xp[i]; s = a <<< 16;
            a = mCoef[24+i]; b = e; s = s + a * b;
            r = fitRow(s); ovf |= r[32]; mX[i] = r[31:0];
        end
        for (int i = 0; i < 4; i++) st[i*32 +: 32] = mX[i];
    endtask

    task automatic modelReset(input bit coefsToo);
        for (int i = 0; i < 4; i++) mX[i] = '0;
        if (coefsToo) for (int i = 0; i < 28; i++) mCoef[i] = '0;
    endtask

    task automatic writeCoef(input int addr, input logic [31:0] data, input bit applies);
        i_cfg_we = 1'b1; i_cfg_addr = 6'(addr); i_cfg_data = data;
        @(negedge i_clk);
        i_cfg_we = 1'b0;
        if (applies && addr < 28) mCoef[addr] = data;
    endtask

    task automatic applyStimulus(input logic [31:0] u, input logic [31:0] y, input bit expectResult);
        exp_t e;
        i_u = u; i_y = y; i_begin = 1'b1;
        if (expectResult) begin
            modelStep(u, y, e.st, e.ovf);
            e.cycle = cyc + 29;
            sbQ.push_back(e);
        end
        @(negedge i_clk);
        i_begin = 1'b0;
        checkOutput("busy_after_accept", o_busy, 1);
    endtask

    task automatic waitIdle();
        int k;
        for (k = 0; k < 80; k++) begin
            @(negedge i_clk);
            if (sbQ.size() == 0 && !o_busy) break;
        end
        if (k == 80) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic waitValid();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_valid) break;
        end
        if (k == 40) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic loadDemoCoefs();
        for (int i = 0; i < 16; i++) writeCoef(i, (i % 5 == 0) ? 32'h8000 : 32'h0, 1);
        writeCoef(1, 32'h2000, 1);
        writeCoef(16, ONE, 1);  writeCoef(17, 32'h8000, 1);
        writeCoef(18, 32'h4000, 1); writeCoef(19, 32'hFFFF_0000, 1);
        writeCoef(20, ONE, 1);  writeCoef(22, 32'h8000, 1);
        writeCoef(24, 32'h4000, 1); writeCoef(25, 32'h2000, 1);
        writeCoef(26, 32'h1000, 1); writeCoef(27, 32'h0800, 1);
    endtask

    // Every o_valid must match the oldest pending prediction, including its arrival cycle.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (o_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("spurious_valid", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("state", o_state, e.st);
                checkOutput("ovf", o_ovf, e.ovf);
                checkOutput("latency", cyc, e.cycle);
                checkOutput("busy_at_valid", o_busy, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ovr0;
        logic [31:0] ru, ry;
        modelReset(1);
        repeat (3) @(negedge i_clk);
        checkOutput("rst_state", o_state, 0);
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_ovf", o_ovf, 0);
        checkOutput("rst_overrun", o_overrun, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Identity A, zero B/C/K: state stays at zero.
        for (int i = 0; i < 4; i++) writeCoef(i*5, ONE, 1);
        applyStimulus(32'h0003_0000, 32'h0001_0000, 1);
        waitIdle();
        checkOutput("t1_state", o_state, 0);

        // Pure input drive: x0 = B0*u = 2.5.
        for (int i = 0; i < 4; i++) writeCoef(i*5, 32'h0, 1);
        writeCoef(16, ONE, 1);
        applyStimulus(32'h0002_8000, 32'h0, 1);
        waitIdle();
        checkOutput("t2_x0", o_state[31:0], 32'h0002_8000);
        checkOutput("t2_rest", o_state[127:32], 0);

        // Pure correction: x0 = 0.5 * (4.0 - 0) = 2.0.
        writeCoef(16, 32'h0, 1);
        writeCoef(20, ONE, 1);
        writeCoef(24, 32'h8000, 1);
        applyStimulus(32'h0, 32'h0004_0000, 1);
        waitIdle();
        checkOutput("t3_x0", o_state[31:0], 32'h0002_0000);
        checkOutput("t3_rest", o_state[127:32], 0);

        // Preload a large x0, then square it through A[0][0] to force overflow.
        writeCoef(20, 32'h0, 1);
        writeCoef(24, 32'h0, 1);
        writeCoef(16, ONE, 1);
        applyStimulus(32'h7FFF_0000, 32'h0, 1);
        waitIdle();
        checkOutput("t4_preload", o_state[31:0], 32'h7FFF_0000);
        writeCoef(0, 32'h7FFF_FFFF, 1);
        writeCoef(16, 32'h0, 1);
        applyStimulus(32'h0, 32'h0, 1);
        waitValid();
        checkOutput("t4_ovf", o_ovf, 1);
`ifdef KF_SATURATE_EN
        checkOutput("t4_x0_sat", o_state[31:0], 32'h7FFF_FFFF);
`else
        checkOutput("t4_x0_wrap", o_state[31:0], 32'h7FFF_8001);
`endif
        waitIdle();

        // Clear in IDLE, then clear together with begin (clear wins, no overrun).
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        modelReset(0);
        checkOutput("clear_idle_state", o_state, 0);
        ovr0 = nOverrun;
        i_clear = 1'b1; i_begin = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0; i_begin = 1'b0;
        @(negedge i_clk);
        checkOutput("clear_begin_busy", o_busy, 0);
        checkOutput("clear_begin_overrun", nOverrun - ovr0, 0);

        // Mixed coefficients with varied samples; one coefficient written alongside i_begin.
        loadDemoCoefs();
        for (int n = 0; n < 3; n++) begin
            ru = $urandom_range(0, 32'h0003_0000);
            ry = $urandom_range(0, 32'h0003_0000);
            applyStimulus(ru, ry, 1);
            waitIdle();
        end
        i_cfg_we = 1'b1; i_cfg_addr = 6'd17; i_cfg_data = 32'h0001_8000;
        mCoef[17] = 32'h0001_8000;
        applyStimulus(32'h0001_0000, 32'h0002_0000, 1);
        i_cfg_we = 1'b0;
        waitIdle();

        // Back-to-back: second sample accepted the cycle after DONE.
        applyStimulus(32'h0000_C000, 32'h0001_4000, 1);
        waitValid();
        @(negedge i_clk);
        applyStimulus(32'hFFFF_8000, 32'h0000_4000, 1);
        waitIdle();

        // i_begin in the middle of a sample only flags an overrun.
        ovr0 = nOverrun;
        applyStimulus(32'h0002_0000, 32'h0001_0000, 1);
        repeat (9) @(negedge i_clk);
        i_u = 32'h1234_0000; i_y = 32'h4321_0000; i_begin = 1'b1;
        @(negedge i_clk);
        i_begin = 1'b0;
        waitIdle();
        checkOutput("overrun_count", nOverrun - ovr0, 1);

        // Asynchronous reset mid-sample aborts and wipes coefficients and state.
        applyStimulus(32'h0001_0000, 32'h0001_0000, 0);
        repeat (14) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_abort_busy", o_busy, 0);
        checkOutput("rst_abort_valid", o_valid, 0);
        checkOutput("rst_abort_state", o_state, 0);
        i_rst_n = 1'b1;
        modelReset(1);
        @(negedge i_clk);

        // Clear mid-sample aborts without o_valid.
        loadDemoCoefs();
        applyStimulus(32'h0002_0000, 32'h0003_0000, 1);
        waitIdle();
        applyStimulus(32'h0001_0000, 32'h0001_0000, 0);
        repeat (14) @(negedge i_clk);
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        modelReset(0);
        checkOutput("clear_abort_busy", o_busy, 0);
        checkOutput("clear_abort_state", o_state, 0);
        repeat (20) @(negedge i_clk);

        // Writes while busy and to out-of-range addresses are ignored.
        applyStimulus(32'h0001_8000, 32'h0000_8000, 1);
        writeCoef(16, 32'h7000_0000, 0);
        waitIdle();
        writeCoef(40, 32'h1234_5678, 1);
        applyStimulus(32'h0001_0000, 32'h0002_0000, 1);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end

endmodule
